// File: rtl/ram_ctrl_pkg.sv
// Shared types for the burst RAM controller: FSM state encoding and
// request direction constants.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/ram_ctrl_timeout.sv
// Per-beat timeout counter: counts while enabled, clears on request,
// flags expiry on the cycle the count sits at TIMEOUT_CYCLES-1 while enabled.
module ram_ctrl_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = en && (count_reg == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr || expired) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ram_burst_controller.sv
// Burst RAM controller: one request drives 1..MAX_BURST sequential beats with
// a per-beat ram_ready timeout. Define RAM_CTRL_STATS_EN for beat/timeout stats.
module ram_burst_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 16,
  parameter int LEN_WIDTH      = $clog2(MAX_BURST),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic                  error,
  output logic                  ram_wr_en,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_ready
`ifdef RAM_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_beats,
  output logic [15:0]           stat_timeouts
`endif
);

  state_t               state;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 active;
  logic                 beat_done;
  logic                 expired;

  assign req_ready = (state == ST_IDLE);
  assign wr_ready  = (state == ST_WRITE) && !ram_wr_en;
  assign active    = ram_rd_en || ram_wr_en;
  assign beat_done = active && ram_ready;

  ram_ctrl_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (beat_done || !active),
    .en     (active && !ram_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      beats_left  <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            error      <= 1'b0;
            ram_addr   <= req_addr;
            beats_left <= req_len;
            if (req_rw == RW_READ) begin
              ram_rd_en <= 1'b1;
              state     <= ST_READ;
            end else begin
              state     <= ST_WRITE;
            end
          end
        end
        ST_READ: begin
          // Completion is checked before expiry so a late ready still counts.
          if (beat_done) begin
            rd_data  <= ram_data_out;
            rd_valid <= 1'b1;
            ram_addr <= ram_addr + 1'b1;
            if (beats_left == '0) begin
              ram_rd_en <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              beats_left <= beats_left - 1'b1;
            end
          end else if (expired) begin
            ram_rd_en <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (ram_wr_en) begin
            if (beat_done) begin
              ram_wr_en <= 1'b0;
              ram_addr  <= ram_addr + 1'b1;
              if (beats_left == '0) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                beats_left <= beats_left - 1'b1;
              end
            end else if (expired) begin
              ram_wr_en <= 1'b0;
              error     <= 1'b1;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end else if (wr_valid) begin
            ram_data_in <= wr_data;
            ram_wr_en   <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef RAM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats    <= '0;
      stat_timeouts <= '0;
    end else begin
      if (beat_done && (stat_beats != '1)) begin
        stat_beats <= stat_beats + 1'b1;
      end
      if (!beat_done && expired && (stat_timeouts != '1)) begin
        stat_timeouts <= stat_timeouts + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_burst_controller.sv
// Directed bench for ram_burst_controller with a small RAM model
// (mem[i] preset to i ^ 8'h5A). Inputs driven and outputs sampled at negedge.
module tb_ram_burst_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [3:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       error;
  logic       ram_wr_en;
  logic       ram_rd_en;
  logic [7:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       ram_ready;
`ifdef RAM_CTRL_STATS_EN
  logic [31:0] stat_beats;
  logic [15:0] stat_timeouts;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  ram_burst_controller #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (8),
    .MAX_BURST     (16),
    .LEN_WIDTH     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw      (req_rw),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .done        (done),
    .error       (error),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .ram_ready   (ram_ready)
`ifdef RAM_CTRL_STATS_EN
    ,
    .stat_beats   (stat_beats),
    .stat_timeouts(stat_timeouts)
`endif
  );

  assign ram_data_out = mem[ram_addr];

  always @(posedge clk) begin
    if (ram_wr_en && ram_ready) mem[ram_addr] <= ram_data_in;
  end

  // Presents a request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input logic rw, input logic [7:0] addr, input logic [3:0] len);
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    $display("req rw=%0d addr=%h len=%0d accepted", rw, addr, len);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({rd_valid, done, error, ram_wr_en, ram_rd_en, wr_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {rd_valid, done, error, ram_wr_en, ram_rd_en, wr_ready});
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
    checks++;
    if ({ram_addr, ram_data_in, rd_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 000000", {ram_addr, ram_data_in, rd_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset test complete");
  endtask

  task automatic test_read_burst;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h4A; exp_rd[1] = 8'h4B; exp_rd[2] = 8'h48; exp_rd[3] = 8'h49;
    ram_ready = 1'b1;
    issue(1'b0, 8'h10, 4'd3);
    checks++;
    if (ram_rd_en !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_start: rd_en=%b req_ready=%b expected 1/0", ram_rd_en, req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_addr !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL read_addr[%0d]: got %h expected %h", i, ram_addr, 8'(8'h10 + i));
      end
      @(negedge clk);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_rd[i]) begin
        errors++;
        $display("FAIL read_beat[%0d]: valid=%b data=%h expected 1/%h", i, rd_valid, rd_data, exp_rd[i]);
      end
      $display("read beat %0d data=%h", i, rd_data);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || ram_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL read_done: done=%b error=%b rd_en=%b expected 1/0/0", done, error, ram_rd_en);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_idle: done=%b req_ready=%b expected 0/1", done, req_ready);
    end
  endtask

  task automatic test_write_wrap;
    logic [7:0] wd [3];
    logic [7:0] wa [3];
    wd[0] = 8'hA1; wd[1] = 8'hA2; wd[2] = 8'hA3;
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00;
    ram_ready = 1'b1;
    issue(1'b1, 8'hFE, 4'd2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL write_ready[%0d]: got %b expected 1", i, wr_ready);
      end
      wr_valid = 1'b1;
      wr_data  = wd[i];
      @(negedge clk);
      wr_valid = 1'b0;
      checks++;
      if (ram_wr_en !== 1'b1 || ram_addr !== wa[i] || ram_data_in !== wd[i] || wr_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_beat[%0d]: en=%b addr=%h data=%h wr_ready=%b expected 1/%h/%h/0",
                 i, ram_wr_en, ram_addr, ram_data_in, wr_ready, wa[i], wd[i]);
      end
      $display("write beat %0d addr=%h data=%h", i, ram_addr, ram_data_in);
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || ram_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL write_done: done=%b error=%b wr_en=%b expected 1/0/0", done, error, ram_wr_en);
    end
    checks++;
    if (mem[8'hFE] !== 8'hA1 || mem[8'hFF] !== 8'hA2 || mem[8'h00] !== 8'hA3) begin
      errors++;
      $display("FAIL write_mem: got %h %h %h expected a1 a2 a3", mem[8'hFE], mem[8'hFF], mem[8'h00]);
    end
    @(negedge clk);
  endtask

  task automatic test_read_wait;
    ram_ready = 1'b0;
    issue(1'b0, 8'h33, 4'd0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_rd_en !== 1'b1 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold[%0d]: rd_en=%b rd_valid=%b expected 1/0", i, ram_rd_en, rd_valid);
      end
      if (i == 3) ram_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (ram_rd_en !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 8'h69 || done !== 1'b1) begin
      errors++;
      $display("FAIL wait_beat: rd_en=%b valid=%b data=%h done=%b expected 0/1/69/1",
               ram_rd_en, rd_valid, rd_data, done);
    end
    $display("waited read data=%h done=%b", rd_data, done);
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_pulse: rd_valid=%b done=%b expected 0/0", rd_valid, done);
    end
  endtask

  task automatic test_timeout;
    int cnt;
    ram_ready = 1'b0;
    issue(1'b1, 8'h40, 4'd0);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    @(negedge clk);
    wr_valid = 1'b0;
    cnt = 0;
    while (ram_wr_en === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL timeout_len: wr_en high %0d cycles expected 8", cnt);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: done=%b error=%b expected 1/1", done, error);
    end
    $display("timeout after %0d cycles error=%b", cnt, error);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: req_ready=%b done=%b expected 1/0", req_ready, done);
    end
    checks++;
    if (mem[8'h40] !== 8'h1A) begin
      errors++;
      $display("FAIL timeout_mem: got %h expected 1a", mem[8'h40]);
    end
    ram_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst;
    ram_ready = 1'b1;
    issue(1'b0, 8'h80, 4'd7);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || ram_addr !== 8'h82) begin
      errors++;
      $display("FAIL midrst_pre: rd_valid=%b addr=%h expected 1/82", rd_valid, ram_addr);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, done, error, ram_wr_en, ram_rd_en} !== 5'b0 || ram_addr !== 8'h00 ||
        rd_data !== 8'h00 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: flags=%b addr=%h rd_data=%h req_ready=%b expected 00000/00/00/1",
               {rd_valid, done, error, ram_wr_en, ram_rd_en}, ram_addr, rd_data, req_ready);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: got %b expected 0", done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("mid-burst reset released");
    issue(1'b0, 8'h05, 4'd0);
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5F || done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: valid=%b data=%h done=%b error=%b expected 1/5f/1/0",
               rd_valid, rd_data, done, error);
    end
    @(negedge clk);
  endtask

`ifdef RAM_CTRL_STATS_EN
  task automatic test_stats;
    int cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ram_ready = 1'b1;
    issue(1'b0, 8'h20, 4'd3);
    for (int i = 0; i < 5; i++) @(negedge clk);
    ram_ready = 1'b0;
    issue(1'b0, 8'h30, 4'd0);
    cnt = 0;
    while (ram_rd_en === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    @(negedge clk);
    ram_ready = 1'b1;
    checks++;
    if (stat_beats !== 32'd4 || stat_timeouts !== 16'd1) begin
      errors++;
      $display("FAIL stats: beats=%0d timeouts=%0d expected 4/1", stat_beats, stat_timeouts);
    end
    $display("stats beats=%0d timeouts=%0d", stat_beats, stat_timeouts);
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    ram_ready = 1'b1;
    test_reset;
    test_read_burst;
    test_write_wrap;
    test_read_wait;
    test_timeout;
    test_reset_mid_burst;
`ifdef RAM_CTRL_STATS_EN
    test_stats;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
